// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle CPU controller:
// states, instruction fields, register selects and control bundle.
package cpu_pkg;

  typedef enum logic [4:0] {
    S_RESET     = 5'd0,
    S_IF1       = 5'd1,
    S_IF2       = 5'd2,
    S_UPDATE_PC = 5'd3,
    S_DECODE    = 5'd4,
    S_WRITE_IMM = 5'd5,
    S_GET_A     = 5'd6,
    S_GET_B     = 5'd7,
    S_ALU       = 5'd8,
    S_WRITE_REG = 5'd9,
    S_ADDR      = 5'd10,
    S_MEM_RD    = 5'd11,
    S_WRITE_MEM = 5'd12,
    S_STR_B     = 5'd13,
    S_MEM_WR    = 5'd14,
    S_HALT      = 5'd15
  } state_t;

  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_MEM     = 2'b00;

  localparam logic [2:0] NSEL_RN = 3'b001;
  localparam logic [2:0] NSEL_RD = 3'b010;
  localparam logic [2:0] NSEL_RM = 3'b100;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_IMM   = 2'b01;
  localparam logic [1:0] VSEL_MDATA = 2'b10;

  // ALU-state flavour, latched in DECODE so outputs stay Moore
  typedef enum logic [1:0] {
    CLS_ARITH,
    CLS_CMP,
    CLS_MOVE
  } alu_cls_t;

  typedef struct packed {
    logic       loadir;
    logic       loadpc;
    logic       reset_pc;
    logic       msel;
    logic       mwrite;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/cpu_ctrl_outputs.sv
// State-to-control decoder; depends only on registered state.
// Unlisted outputs stay 0 in every state.
module cpu_ctrl_outputs
  import cpu_pkg::*;
(
  input  state_t   state,
  input  alu_cls_t cls,
  output ctrl_t    ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_RESET: begin
        ctrl.reset_pc = 1'b1;
        ctrl.loadpc   = 1'b1;
      end
      S_IF2:       ctrl.loadir = 1'b1;
      S_UPDATE_PC: ctrl.loadpc = 1'b1;
      S_WRITE_IMM: begin
        ctrl.nsel  = NSEL_RN;
        ctrl.vsel  = VSEL_IMM;
        ctrl.write = 1'b1;
      end
      S_GET_A: begin
        ctrl.nsel  = NSEL_RN;
        ctrl.loada = 1'b1;
      end
      S_GET_B: begin
        ctrl.nsel  = NSEL_RM;
        ctrl.loadb = 1'b1;
      end
      S_ALU: begin
        if (cls == CLS_CMP) begin
          ctrl.loads = 1'b1;
        end else begin
          ctrl.loadc = 1'b1;
          ctrl.asel  = (cls == CLS_MOVE);
        end
      end
      S_WRITE_REG: begin
        ctrl.nsel  = NSEL_RD;
        ctrl.vsel  = VSEL_C;
        ctrl.write = 1'b1;
      end
      S_ADDR: begin
        ctrl.bsel  = 1'b1;
        ctrl.loadc = 1'b1;
      end
      S_MEM_RD:    ctrl.msel = 1'b1;
      S_WRITE_MEM: begin
        ctrl.msel  = 1'b1;
        ctrl.nsel  = NSEL_RD;
        ctrl.vsel  = VSEL_MDATA;
        ctrl.write = 1'b1;
      end
      S_STR_B: begin
        ctrl.msel  = 1'b1;
        ctrl.nsel  = NSEL_RD;
        ctrl.loadb = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.msel   = 1'b1;
        ctrl.mwrite = 1'b1;
      end
      S_HALT:  ctrl.halted = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle fetch/decode/execute sequencer for the simple CPU.
// Moore FSM: next-state here, output decode in cpu_ctrl_outputs.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       loadir,
  output logic       loadpc,
  output logic       reset_pc,
  output logic       msel,
  output logic       mwrite,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       halted,
  output logic [4:0] state_out
);

  state_t   state_q, state_d;
  alu_cls_t cls_q, cls_d;
  ctrl_t    ctrl;
  logic     is_mem;

  assign is_mem = (opcode == OPC_LDR) || (opcode == OPC_STR);

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    case (state_q)
      S_RESET:     state_d = S_IF1;
      S_IF1:       state_d = S_IF2;
      S_IF2:       state_d = S_UPDATE_PC;
      S_UPDATE_PC: state_d = S_DECODE;
      S_DECODE: begin
        cls_d = CLS_ARITH;
        unique casez ({opcode, op})
          {OPC_MOV, OP_MOV_IMM}: state_d = S_WRITE_IMM;
          {OPC_MOV, OP_MOV_REG}: begin
            state_d = S_GET_B;
            cls_d   = CLS_MOVE;
          end
          {OPC_ALU, OP_ADD},
          {OPC_ALU, OP_AND}:     state_d = S_GET_A;
          {OPC_ALU, OP_CMP}: begin
            state_d = S_GET_A;
            cls_d   = CLS_CMP;
          end
          {OPC_ALU, OP_MVN}: begin
            state_d = S_GET_B;
            cls_d   = CLS_MOVE;
          end
          {OPC_LDR, OP_MEM},
          {OPC_STR, OP_MEM}:     state_d = S_GET_A;
          {OPC_HALT, 2'b??}:     state_d = S_HALT;
          default: state_d = HALT_ON_ILLEGAL ? S_HALT : S_IF1;
        endcase
      end
      S_WRITE_IMM: state_d = S_IF1;
      S_GET_A:     state_d = is_mem ? S_ADDR : S_GET_B;
      S_GET_B:     state_d = S_ALU;
      S_ALU:       state_d = (cls_q == CLS_CMP) ? S_IF1 : S_WRITE_REG;
      S_WRITE_REG: state_d = S_IF1;
      S_ADDR:      state_d = (opcode == OPC_STR) ? S_STR_B : S_MEM_RD;
      S_MEM_RD:    state_d = S_WRITE_MEM;
      S_WRITE_MEM: state_d = S_IF1;
      S_STR_B:     state_d = S_MEM_WR;
      S_MEM_WR:    state_d = S_IF1;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RESET;
      cls_q   <= CLS_ARITH;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
    end
  end

  cpu_ctrl_outputs u_out (
    .state (state_q),
    .cls   (cls_q),
    .ctrl  (ctrl)
  );

  assign loadir    = ctrl.loadir;
  assign loadpc    = ctrl.loadpc;
  assign reset_pc  = ctrl.reset_pc;
  assign msel      = ctrl.msel;
  assign mwrite    = ctrl.mwrite;
  assign nsel      = ctrl.nsel;
  assign vsel      = ctrl.vsel;
  assign write     = ctrl.write;
  assign loada     = ctrl.loada;
  assign loadb     = ctrl.loadb;
  assign loadc     = ctrl.loadc;
  assign loads     = ctrl.loads;
  assign asel      = ctrl.asel;
  assign bsel      = ctrl.bsel;
  assign halted    = ctrl.halted;
  assign state_out = state_q;

endmodule
